// File: rtl/servo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_ctrl_pkg
// Description : Shared constants and helpers for the servo axis controller.
//               Provides the centre-position function, counter/product width
//               helpers and the default timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_ctrl_pkg;

    // Default timing for a 50 MHz clock and standard hobby servos.
    localparam int c_default_n_axes         = 3;
    localparam int c_default_pos_width      = 10;
    localparam int c_default_pwm_period_cyc = 1_000_000;
    localparam int c_default_pulse_min_cyc  = 50_000;
    localparam int c_default_pulse_max_cyc  = 100_000;
    localparam int c_default_slew_div       = 50_000;
    localparam int c_default_slew_step      = 1;

    // Mid-scale position, used as the reset position of every axis.
    function automatic int center_pos(input int width);
        return 1 << (width - 1);
    endfunction

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed for the position-times-span product of the width map.
    function automatic int prod_bits(input int pos_width, input int span);
        return pos_width + cnt_bits(span);
    endfunction

    // Pulse width that corresponds to a given position.
    function automatic int pos_to_width(input int pos, input int pos_width,
                                        input int pulse_min, input int pulse_max);
        return pulse_min + ((pos * (pulse_max - pulse_min)) >> pos_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_channel
// Description : One servo axis: target select, rate-limited slew register,
//               registered at-target flag, position-to-width map, per-frame
//               width latch and PWM compare.
// Ports       : clk, rst            clock, async active-high reset
//               select_source, hold target select / freeze control
//               slew_tick           one-cycle slew strobe from the top
//               frame_start         high while the shared PWM counter is 0
//               pwm_cnt             shared PWM frame counter
//               pos_mem, pos_accel  candidate targets for this axis
//               pos_current         commanded position
//               at_target, pwm_out  registered status and servo pin
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_channel
    import servo_ctrl_pkg::*;
#(
    parameter int POS_WIDTH     = c_default_pos_width,
    parameter int PULSE_MIN_CYC = c_default_pulse_min_cyc,
    parameter int PULSE_MAX_CYC = c_default_pulse_max_cyc,
    parameter int SLEW_STEP     = c_default_slew_step,
    parameter int CNT_W         = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 select_source,
    input  logic                 hold,
    input  logic                 slew_tick,
    input  logic                 frame_start,
    input  logic [CNT_W-1:0]     pwm_cnt,
    input  logic [POS_WIDTH-1:0] pos_mem,
    input  logic [POS_WIDTH-1:0] pos_accel,
    output logic [POS_WIDTH-1:0] pos_current,
    output logic                 at_target,
    output logic                 pwm_out
);

    localparam int c_span         = PULSE_MAX_CYC - PULSE_MIN_CYC;
    localparam int c_prod_w       = prod_bits(POS_WIDTH, c_span);
    localparam int c_width_w      = cnt_bits(PULSE_MAX_CYC + 1);
    localparam int c_cmp_w        = (CNT_W > c_width_w) ? CNT_W : c_width_w;
    localparam int c_max_pos      = (1 << POS_WIDTH) - 1;
    // A step larger than full scale behaves exactly like full scale.
    localparam int c_step_clip    = (SLEW_STEP > c_max_pos) ? c_max_pos : SLEW_STEP;
    localparam int c_center_width = pos_to_width(center_pos(POS_WIDTH), POS_WIDTH,
                                                 PULSE_MIN_CYC, PULSE_MAX_CYC);

    localparam logic [POS_WIDTH:0]   c_step_ext = (POS_WIDTH+1)'(c_step_clip);
    localparam logic [POS_WIDTH-1:0] c_step     = POS_WIDTH'(c_step_clip);
    localparam logic [POS_WIDTH-1:0] c_center   = POS_WIDTH'(center_pos(POS_WIDTH));

    logic [POS_WIDTH-1:0] r_cur;
    logic                 r_at_target;
    logic [c_width_w-1:0] r_width;
    logic                 r_pwm;

    logic [POS_WIDTH-1:0] w_tgt;
    logic                 w_up;
    logic [POS_WIDTH:0]   w_diff;
    logic [POS_WIDTH-1:0] w_step;
    logic [POS_WIDTH-1:0] w_cur_next;
    logic [c_prod_w-1:0]  w_prod;
    logic [c_prod_w-1:0]  w_scaled;
    logic [c_width_w-1:0] w_width;
    logic [c_width_w-1:0] w_width_eff;

    // Target is sampled live so a source switch mid-ramp simply redirects
    // the ramp from wherever the axis currently is.
    assign w_tgt = select_source ? pos_accel : pos_mem;

    // Distance in W+1 bits; the step is clipped to the distance so the
    // position can neither overshoot nor wrap past 0 or full scale.
    assign w_up       = (w_tgt > r_cur);
    assign w_diff     = w_up ? ({1'b0, w_tgt} - {1'b0, r_cur})
                             : ({1'b0, r_cur} - {1'b0, w_tgt});
    assign w_step     = (w_diff < c_step_ext) ? w_diff[POS_WIDTH-1:0] : c_step;
    assign w_cur_next = w_up ? (r_cur + w_step) : (r_cur - w_step);

    // Product is wide enough for full-scale position times span.
    assign w_prod   = c_prod_w'(r_cur) * c_prod_w'(c_span);
    assign w_scaled = w_prod >> POS_WIDTH;
    assign w_width  = c_width_w'(PULSE_MIN_CYC) + c_width_w'(w_scaled);

    // At frame start the freshly mapped width is used directly so the first
    // compare of the frame already sees the new width.
    assign w_width_eff = frame_start ? w_width : r_width;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur       <= c_center;
            r_at_target <= 1'b0;
            r_width     <= c_width_w'(c_center_width);
            r_pwm       <= 1'b0;
        end else begin
            if (slew_tick && !hold) begin
                r_cur <= w_cur_next;
            end
            r_at_target <= (r_cur == w_tgt);
            // Latching uses the pre-tick position even when a slew tick
            // lands on the same cycle.
            if (frame_start) begin
                r_width <= w_width;
            end
            r_pwm <= (c_cmp_w'(pwm_cnt) < c_cmp_w'(w_width_eff));
        end
    end

    assign pos_current = r_cur;
    assign at_target   = r_at_target;
    assign pwm_out     = r_pwm;

endmodule
`default_nettype wire

// File: rtl/servo_axis_controller.sv
`default_nettype none
// ============================================================================
// Module      : servo_axis_controller
// Description : N-axis servo position controller. Holds the shared slew and
//               PWM frame counters, one servo_pwm_channel per axis, and the
//               all-axes-at-target reduction.
// Ports       : clk, rst                async active-high reset
//               select_source           0 = pos_mem, 1 = pos_accel
//               hold                    freeze all commanded positions
//               pos_mem, pos_accel      packed targets, axis i at [i*W +: W]
//               pos_current             packed commanded positions
//               at_target, all_at_target, pwm_out
// Revision    : 1.0 - initial release
// ============================================================================
module servo_axis_controller
    import servo_ctrl_pkg::*;
#(
    parameter int N_AXES         = c_default_n_axes,
    parameter int POS_WIDTH      = c_default_pos_width,
    parameter int PWM_PERIOD_CYC = c_default_pwm_period_cyc,
    parameter int PULSE_MIN_CYC  = c_default_pulse_min_cyc,
    parameter int PULSE_MAX_CYC  = c_default_pulse_max_cyc,
    parameter int SLEW_DIV       = c_default_slew_div,
    parameter int SLEW_STEP      = c_default_slew_step
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          select_source,
    input  logic                          hold,
    input  logic [N_AXES*POS_WIDTH-1:0]   pos_mem,
    input  logic [N_AXES*POS_WIDTH-1:0]   pos_accel,
    output logic [N_AXES*POS_WIDTH-1:0]   pos_current,
    output logic [N_AXES-1:0]             at_target,
    output logic                          all_at_target,
    output logic [N_AXES-1:0]             pwm_out
);

    localparam int c_slew_w = cnt_bits(SLEW_DIV);
    localparam int c_pwm_w  = cnt_bits(PWM_PERIOD_CYC);

    localparam logic [c_slew_w-1:0] c_slew_last = c_slew_w'(SLEW_DIV - 1);
    localparam logic [c_pwm_w-1:0]  c_pwm_last  = c_pwm_w'(PWM_PERIOD_CYC - 1);

    logic [c_slew_w-1:0]  r_slew_cnt;
    logic [c_pwm_w-1:0]   r_pwm_cnt;
    logic                 w_tick;
    logic                 w_frame_start;

    logic [POS_WIDTH-1:0] w_cur [N_AXES];
    logic                 w_at  [N_AXES];
    logic                 w_pwm [N_AXES];

    assign w_tick        = (r_slew_cnt == c_slew_last);
    assign w_frame_start = (r_pwm_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slew_cnt <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_slew_cnt <= w_tick ? '0 : (r_slew_cnt + 1'b1);
            r_pwm_cnt  <= (r_pwm_cnt == c_pwm_last) ? '0 : (r_pwm_cnt + 1'b1);
        end
    end

    for (genvar gi = 0; gi < N_AXES; gi++) begin : g_axis
        servo_pwm_channel #(
            .POS_WIDTH     (POS_WIDTH),
            .PULSE_MIN_CYC (PULSE_MIN_CYC),
            .PULSE_MAX_CYC (PULSE_MAX_CYC),
            .SLEW_STEP     (SLEW_STEP),
            .CNT_W         (c_pwm_w)
        ) u_channel (
            .clk           (clk),
            .rst           (rst),
            .select_source (select_source),
            .hold          (hold),
            .slew_tick     (w_tick),
            .frame_start   (w_frame_start),
            .pwm_cnt       (r_pwm_cnt),
            .pos_mem       (pos_mem[gi*POS_WIDTH +: POS_WIDTH]),
            .pos_accel     (pos_accel[gi*POS_WIDTH +: POS_WIDTH]),
            .pos_current   (w_cur[gi]),
            .at_target     (w_at[gi]),
            .pwm_out       (w_pwm[gi])
        );
    end

    // Repack per-axis results onto the flat output buses.
    always_comb begin
        pos_current = '0;
        at_target   = '0;
        pwm_out     = '0;
        for (int i = 0; i < N_AXES; i++) begin
            pos_current[i*POS_WIDTH +: POS_WIDTH] = w_cur[i];
            at_target[i]                          = w_at[i];
            pwm_out[i]                            = w_pwm[i];
        end
    end

    assign all_at_target = &at_target;

endmodule
`default_nettype wire

// File: tb/tb_servo_axis_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_axis_controller
// Description : Self-checking bench for servo_axis_controller. Two instances
//               (slew step 1 and slew step 3) are compared every cycle against
//               a behavioural model; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_axis_controller;

    localparam int c_n      = 3;
    localparam int c_w      = 4;
    localparam int c_period = 100;
    localparam int c_min    = 10;
    localparam int c_max    = 20;
    localparam int c_div    = 4;

    logic clk = 1'b0;
    logic rst;

    logic                  sel_a, hold_a, sel_b, hold_b;
    logic [c_n*c_w-1:0]    mem_a, accel_a, mem_b, accel_b;
    logic [c_n*c_w-1:0]    cur_a, cur_b;
    logic [c_n-1:0]        at_a, at_b, pwm_a, pwm_b;
    logic                  all_a, all_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    servo_axis_controller #(
        .N_AXES(c_n), .POS_WIDTH(c_w), .PWM_PERIOD_CYC(c_period),
        .PULSE_MIN_CYC(c_min), .PULSE_MAX_CYC(c_max),
        .SLEW_DIV(c_div), .SLEW_STEP(1)
    ) dut (
        .clk(clk), .rst(rst), .select_source(sel_a), .hold(hold_a),
        .pos_mem(mem_a), .pos_accel(accel_a), .pos_current(cur_a),
        .at_target(at_a), .all_at_target(all_a), .pwm_out(pwm_a)
    );

    servo_axis_controller #(
        .N_AXES(c_n), .POS_WIDTH(c_w), .PWM_PERIOD_CYC(c_period),
        .PULSE_MIN_CYC(c_min), .PULSE_MAX_CYC(c_max),
        .SLEW_DIV(c_div), .SLEW_STEP(3)
    ) dut_step3 (
        .clk(clk), .rst(rst), .select_source(sel_b), .hold(hold_b),
        .pos_mem(mem_b), .pos_accel(accel_b), .pos_current(cur_b),
        .at_target(at_b), .all_at_target(all_b), .pwm_out(pwm_b)
    );

    // ------------------------------------------------------------------
    // Behavioural model: plain integer arithmetic on the control rules.
    // ------------------------------------------------------------------
    int m_cur  [2][c_n];
    int m_wl   [2][c_n];
    int m_at   [2][c_n];
    int m_pwm  [2][c_n];
    int m_scnt [2];
    int m_pcnt [2];

    function automatic int field(input logic [c_n*c_w-1:0] v, input int i);
        return int'((v >> (c_w*i)) & 12'hF);
    endfunction

    function automatic int target_of(input int k, input int i);
        if (k == 0) return sel_a ? field(accel_a, i) : field(mem_a, i);
        return sel_b ? field(accel_b, i) : field(mem_b, i);
    endfunction

    function automatic int width_of(input int pos);
        return c_min + (pos * (c_max - c_min)) / (1 << c_w);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_scnt[k] = 0;
            m_pcnt[k] = 0;
            for (int i = 0; i < c_n; i++) begin
                m_cur[k][i] = 8;
                m_wl[k][i]  = width_of(8);
                m_at[k][i]  = 0;
                m_pwm[k][i] = 0;
            end
        end
    endtask

    task automatic model_step(input int k);
        int  step, t, d;
        bit  tick, frame, hld;
        step  = (k == 0) ? 1 : 3;
        hld   = (k == 0) ? hold_a : hold_b;
        tick  = (m_scnt[k] == c_div - 1);
        frame = (m_pcnt[k] == 0);
        for (int i = 0; i < c_n; i++) begin
            t = target_of(k, i);
            m_at[k][i] = (m_cur[k][i] == t) ? 1 : 0;
            if (frame) m_wl[k][i] = width_of(m_cur[k][i]);
            m_pwm[k][i] = (m_pcnt[k] < m_wl[k][i]) ? 1 : 0;
            if (tick && !hld) begin
                d = (t > m_cur[k][i]) ? t - m_cur[k][i] : m_cur[k][i] - t;
                if (d > step) d = step;
                m_cur[k][i] = (t > m_cur[k][i]) ? m_cur[k][i] + d : m_cur[k][i] - d;
            end
        end
        m_scnt[k] = (m_scnt[k] + 1) % c_div;
        m_pcnt[k] = (m_pcnt[k] + 1) % c_period;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_cur(input int k, input int i);
        return (k == 0) ? field(cur_a, i) : field(cur_b, i);
    endfunction

    function automatic logic pwm_bit(input int k, input int i);
        return (k == 0) ? pwm_a[i] : pwm_b[i];
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int all_exp;
            all_exp = 1;
            for (int i = 0; i < c_n; i++) begin
                check($sformatf("model_cur_d%0d_a%0d", k, i), dut_cur(k, i), m_cur[k][i]);
                check($sformatf("model_at_d%0d_a%0d", k, i),
                      (k == 0) ? at_a[i] : at_b[i], m_at[k][i]);
                check($sformatf("model_pwm_d%0d_a%0d", k, i), pwm_bit(k, i), m_pwm[k][i]);
                if (m_at[k][i] == 0) all_exp = 0;
            end
            check($sformatf("model_all_d%0d", k), (k == 0) ? all_a : all_b, all_exp);
        end
    end

    // Measures the next complete high pulse on one pin, in cycles.
    task automatic measure_pulse(input int k, input int ax, output int width);
        int guard;
        width = 0;
        guard = 0;
        while (pwm_bit(k, ax) == 1'b1 && guard < 300) begin @(negedge clk); guard++; end
        guard = 0;
        while (pwm_bit(k, ax) == 1'b0 && guard < 300) begin @(negedge clk); guard++; end
        while (pwm_bit(k, ax) == 1'b1 && width < 300) begin width++; @(negedge clk); end
    endtask

    task automatic wait_cur(input int k, input int ax, input int value, input int limit,
                            input string name);
        int n;
        n = 0;
        while (dut_cur(k, ax) != value && n < limit) begin @(negedge clk); n++; end
        check(name, dut_cur(k, ax), value);
    endtask

    task automatic wait_change(input int k, input int ax, input int old, input int limit);
        int n;
        n = 0;
        while (dut_cur(k, ax) == old && n < limit) begin @(negedge clk); n++; end
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int w, prev, n;
        rst     = 1'b1;
        sel_a   = 1'b0; hold_a = 1'b0; mem_a = 12'h888; accel_a = 12'h888;
        sel_b   = 1'b0; hold_b = 1'b0; mem_b = 12'h888; accel_b = 12'h888;

        // 1: reset state and centre pulse width
        repeat (3) @(negedge clk);
        check("reset_cur", cur_a, 12'h888);
        check("reset_at", at_a, 0);
        check("reset_all", all_a, 0);
        check("reset_pwm", pwm_a, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("first_frame_pwm", pwm_a, 3'b111);
        measure_pulse(0, 0, w);
        check("pulse_center_ax0", w, 15);
        measure_pulse(0, 2, w);
        check("pulse_center_ax2", w, 15);

        // 2: ramp axis 0 up to full scale
        mem_a = 12'h88F;
        wait_cur(0, 0, 15, 60, "ramp_up_end");
        check("at_before_rise", at_a[0], 0);
        @(negedge clk);
        check("at_rise", at_a[0], 1);
        measure_pulse(0, 0, w);
        check("pulse_full_scale", w, 19);

        // 3: switch source mid-ramp, ramp down to zero without a jump
        mem_a = 12'h88C;
        wait_cur(0, 0, 12, 100, "ramp_to_12");
        accel_a = 12'h850;
        sel_a   = 1'b1;
        prev = 12;
        n    = 0;
        while (dut_cur(0, 0) != 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (dut_cur(0, 0) != prev) begin
                check("ramp_down_step", prev - dut_cur(0, 0), 1);
                prev = dut_cur(0, 0);
            end
        end
        check("ramp_down_end", dut_cur(0, 0), 0);
        measure_pulse(0, 0, w);
        check("pulse_zero", w, 10);

        // 4: hold freezes axis 1 while the PWM keeps running
        check("hold_start_cur1", dut_cur(0, 1), 5);
        hold_a  = 1'b1;
        accel_a = 12'h8F0;
        repeat (40) begin
            @(negedge clk);
            check("hold_cur1", dut_cur(0, 1), 5);
        end
        measure_pulse(0, 1, w);
        check("hold_pulse", w, 13);
        hold_a = 1'b0;
        wait_change(0, 1, 5, 10);
        check("hold_release_step", dut_cur(0, 1), 6);

        // 5: step of 3 with no overshoot
        mem_b = 12'h889;
        wait_change(1, 0, 8, 10);
        check("step3_small", dut_cur(1, 0), 9);
        repeat (10) @(negedge clk);
        check("step3_settled", dut_cur(1, 0), 9);
        mem_b = 12'h88F;
        wait_change(1, 0, 9, 10);
        check("step3_first", dut_cur(1, 0), 12);
        wait_change(1, 0, 12, 10);
        check("step3_second", dut_cur(1, 0), 15);

        // 6: asynchronous reset in the middle of a pulse
        n = 0;
        while (pwm_a[0] == 1'b1 && n < 300) begin @(negedge clk); n++; end
        n = 0;
        while (pwm_a[0] == 1'b0 && n < 300) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check("pwm_before_rst", pwm_a[0], 1);
        #2 rst = 1'b1;
        #1;
        check("rst_pwm_immediate", pwm_a, 0);
        check("rst_cur_immediate", cur_a, 12'h888);
        check("rst_cur_step3", cur_b, 12'h888);
        check("rst_all_immediate", all_a, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
